led_pwm_status: RTL

- Parametrised N-channel LED PWM/status driver; successor to the fixed on/off LED drive used in the board top-levels.
- Per-channel mode: off, steady, blink or breathe, each at a programmable brightness level.
- Sits between CPU/test-bench status signals and the SB_RGBA_DRV PWM inputs; one instance per board.

---
 rtl/led_pwm_status.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/led_pwm_status.sv
// N-channel LED PWM/status driver: off / steady / blink / breathe per channel, frame-aligned duty updates.
// Optional perceptual gamma (d*d >> PWM_BITS) on the latched duty when LED_PWM_GAMMA_EN is defined.
module led_pwm_status #(
    parameter int unsigned CLK_FREQ       = 12_000_000,
    parameter int unsigned N_CH           = 3,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned BLINK_HZ       = 2,
    parameter int unsigned BREATHE_FRAMES = 184
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [2*N_CH-1:0]          i_mode,
    input  logic [N_CH*PWM_BITS-1:0]   i_level,
    output logic [N_CH-1:0]            o_pwm,
    output logic                       o_frame,
    output logic                       o_blink
);

    localparam int unsigned HALF_PERIOD = CLK_FREQ / (2 * BLINK_HZ);
    localparam int unsigned BLINK_W     = $clog2(HALF_PERIOD);
    localparam int unsigned STEP_W      = (BREATHE_FRAMES > 1) ? $clog2(BREATHE_FRAMES) : 1;
    localparam int unsigned PROD_W      = 2 * PWM_BITS;

    localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(HALF_PERIOD - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(BREATHE_FRAMES - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STEADY  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                frame_q, frame_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_q, blink_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PWM_BITS-1:0] br_q, br_d;
    dir_e                dir_q, dir_d;
    logic [PWM_BITS-1:0] duty_q [N_CH];
    logic [PWM_BITS-1:0] duty_d [N_CH];
    logic [N_CH-1:0]     pwm_q, pwm_d;

    mode_e               ch_mode;
    logic [PWM_BITS-1:0] ch_level;
    logic [PWM_BITS-1:0] mode_duty [N_CH];
    logic [PWM_BITS-1:0] eff_duty  [N_CH];

    // Shared timebase: frame counter, blink phase and breathe triangle.
    always_comb begin
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        frame_d     = (pwm_cnt_d == PWM_MAX);
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_d     = blink_q;
        step_d      = step_q;
        br_d        = br_q;
        dir_d       = dir_q;

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end

        if (frame_q) begin
            if (step_q == STEP_LAST) begin
                step_d = '0;
                case (dir_q)
                    DIR_UP: begin
                        if (br_q == PWM_MAX) begin
                            br_d  = PWM_MAX - PWM_BITS'(1);
                            dir_d = DIR_DOWN;
                        end else begin
                            br_d = br_q + PWM_BITS'(1);
                        end
                    end
                    DIR_DOWN: begin
                        // Bounce off zero so the ramp never dwells at either end.
                        if (br_q == '0) begin
                            br_d  = PWM_BITS'(1);
                            dir_d = DIR_UP;
                        end else begin
                            br_d = br_q - PWM_BITS'(1);
                        end
                    end
                    default: begin
                        br_d  = '0;
                        dir_d = DIR_UP;
                    end
                endcase
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    // Per-channel target duty from mode, level and shared blink/breathe state.
    always_comb begin
        ch_mode  = MODE_OFF;
        ch_level = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            mode_duty[c] = '0;
            eff_duty[c]  = '0;
        end
        for (int unsigned c = 0; c < N_CH; c++) begin
            ch_mode  = mode_e'(i_mode[2*c +: 2]);
            ch_level = i_level[c*PWM_BITS +: PWM_BITS];
            case (ch_mode)
                MODE_OFF:     mode_duty[c] = '0;
                MODE_STEADY:  mode_duty[c] = ch_level;
                MODE_BLINK:   mode_duty[c] = blink_q ? ch_level : '0;
                MODE_BREATHE: mode_duty[c] =
                    PWM_BITS'((PROD_W'(ch_level) * PROD_W'(br_q)) >> PWM_BITS);
                default:      mode_duty[c] = '0;
            endcase
`ifdef LED_PWM_GAMMA_EN
            eff_duty[c] = PWM_BITS'((PROD_W'(mode_duty[c]) * PROD_W'(mode_duty[c])) >> PWM_BITS);
`else
            eff_duty[c] = mode_duty[c];
`endif
        end
    end

    // Duty only moves at the frame boundary so a frame is never cut short or stretched.
    always_comb begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            duty_d[c] = duty_q[c];
            pwm_d[c]  = (pwm_cnt_q < duty_q[c]);
        end
        if (pwm_cnt_q == PWM_MAX) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                duty_d[c] = eff_duty[c];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_cnt_q   <= '0;
            frame_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            step_q      <= '0;
            br_q        <= '0;
            dir_q       <= DIR_UP;
            pwm_q       <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                duty_q[c] <= '0;
            end
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            frame_q     <= frame_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            step_q      <= step_d;
            br_q        <= br_d;
            dir_q       <= dir_d;
            pwm_q       <= pwm_d;
            for (int unsigned c = 0; c < N_CH; c++) begin
                duty_q[c] <= duty_d[c];
            end
        end
    end

    assign o_pwm   = pwm_q;
    assign o_frame = frame_q;
    assign o_blink = blink_q;

endmodule
